mod_counter_seq: RTL and testbench
==================================

MOD_COUNTER_SEQ -- requirements
Module: mod_counter_seq

Interface
REQ-001 SHALL have parameter N, default 10: counter modulus, legal range 2..2^A.
REQ-002 SHALL have parameter A, default 4: counter width in bits.
REQ-003 SHALL have parameter W, default 8: width of the wrap-count fields.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_valid, input, 1: a run request is offered.
REQ-007 SHALL have port start_ready, output, 1: the block can accept a request.
REQ-008 SHALL have port start_wraps, input, W: number of full mod-N cycles to run.
REQ-009 SHALL have port pause, input, 1: freeze the count while high.
REQ-010 SHALL have port abort, input, 1: end the run early.
REQ-011 SHALL have port counter, output, A: current count value.
REQ-012 SHALL have port wrap_pulse, output, 1: one-cycle marker for each N-1 to 0 wrap.
REQ-013 SHALL have port wraps_left, output, W: number of wraps still to complete.
REQ-014 SHALL have port busy, output, 1: high in RUN and HOLD.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a run completes normally.

Function
REQ-016 SHALL implement a state machine with states IDLE, RUN, HOLD and DONE.
REQ-017 SHALL drive start_ready high only in IDLE and never while reset is high.
REQ-018 SHALL accept a request on an edge where start_valid and start_ready are both high.
  - start_wraps > 0: next state RUN; counter = 0; wraps_left = start_wraps.
  - start_wraps = 0: next state DONE.
REQ-019 SHALL, in RUN with pause low, advance counter by 1 on each edge.
  - counter = N-1 wraps to 0.
  - On that wrap edge: wrap_pulse = 1 and wraps_left decrements.
REQ-020 SHALL register wrap_pulse so it is high exactly in the cycle where counter first shows 0 after N-1.
REQ-021 SHALL end a run when wraps_left goes from 1 to 0.
  - On that edge: next state DONE, counter = 0, wrap_pulse = 1.
  - A run of K wraps takes exactly K*N edges in RUN.
REQ-022 SHALL stay in DONE for exactly one cycle with done = 1, then return to IDLE.
REQ-023 SHALL, when pause is high in RUN, enter HOLD on the next edge.
  - counter and wraps_left are frozen while in HOLD.
  - The state returns to RUN on the edge after pause falls.
REQ-024 SHALL, when abort is high in RUN or HOLD, go to IDLE on the next edge.
  - counter = 0, wraps_left = 0.
  - done is not pulsed and wrap_pulse is not asserted.
REQ-025 SHALL resolve simultaneous events by priority: reset, then abort, then pause, then the count/wrap step.
  - Abort on the final wrap edge wins: no done pulse.
REQ-026 SHALL ignore abort and pause in IDLE and DONE.
REQ-027 SHALL ignore start_valid outside IDLE; no request is queued.

Reset
REQ-028 SHALL apply the following on any edge with reset high, regardless of state:
  - State = IDLE.
  - counter = 0, wraps_left = 0.
  - wrap_pulse = 0, done = 0, busy = 0, start_ready = 0.
REQ-029 SHALL assert start_ready in the first cycle after reset falls.
REQ-030 SHALL discard an in-flight run on reset mid-operation, with no done pulse.

Configuration
REQ-031 SHALL honour pause as in REQ-023 when macro MOD_COUNTER_SEQ_PAUSE_EN is defined.
REQ-032 SHALL, when MOD_COUNTER_SEQ_PAUSE_EN is not defined:
  - Keep the pause port but ignore it.
  - Never enter HOLD.

Structure
REQ-033 SHALL take the state enum and the state encoding localparams from shared package mod_counter_seq_pkg.
REQ-034 SHALL instantiate one sub-module, mod_cnt_core.
  - mod_cnt_core is a parameterised mod-N counter.
  - Its inputs are clk, reset, clear and enable; its outputs are count and a wrap flag.
  - The FSM drives its clear and enable.

Verification (N=10, A=4, W=8)
REQ-035 SHALL cover a basic run: start_wraps=3 accepted.
  - 30 RUN cycles, counter 0..9 three times.
  - wrap_pulse three times; wraps_left 3, 2, 1, 0.
  - done for 1 cycle, then start_ready = 1.
REQ-036 SHALL cover zero wraps: start_wraps=0 accepted.
  - done on the next cycle.
  - counter stays 0; wrap_pulse never asserted.
REQ-037 SHALL cover pause, with PAUSE_EN defined: pause for 5 cycles at counter=4.
  - counter holds 4 and busy = 1 throughout.
  - Counting resumes to 5 after pause falls.
  - The run is 5 cycles longer in total.
REQ-038 SHALL cover abort on the final-wrap cycle (counter=9, wraps_left=1).
  - Next cycle: IDLE, counter=0, wrap_pulse=0, done never asserted.
REQ-039 SHALL cover reset mid-run at counter=6.
  - Next cycle: all outputs 0.
  - start_ready = 1 one cycle after reset falls.
  - start_valid during the run was ignored.

Source files
------------

// File: rtl/mod_counter_seq_pkg.sv
// Shared types for the mod-N run sequencer: FSM state encoding and a busy decode helper.
package mod_counter_seq_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD_ENC = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_HOLD = ST_HOLD_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/mod_cnt_core.sv
// Parameterised mod-N counter with synchronous clear/enable and a terminal-count flag.
module mod_cnt_core #(
  parameter int unsigned N = 10,
  parameter int unsigned A = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [A-1:0] count,
  output logic         wrap_c
);

  localparam logic [A-1:0] LAST = A'(N - 1);

  logic [A-1:0] r_count;

  // Flag is independent of enable so the controller can gate it without a comb loop.
  assign wrap_c = (r_count == LAST);
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : A'(r_count + A'(1));
    end
  end

endmodule

// File: rtl/mod_counter_seq.sv
// Runs a mod-N counter for a requested number of wraps; supports abort and,
// when MOD_COUNTER_SEQ_PAUSE_EN is defined, pause.
module mod_counter_seq
  import mod_counter_seq_pkg::*;
#(
  parameter int unsigned N = 10,
  parameter int unsigned A = 4,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] start_wraps,
  input  logic         pause,
  input  logic         abort,
  output logic [A-1:0] counter,
  output logic         wrap_pulse,
  output logic [W-1:0] wraps_left,
  output logic         busy,
  output logic         done
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_wraps_left;
  logic [W-1:0] w_wraps_left_nxt;
  logic         r_wrap_pulse;
  logic         r_done;
  logic         r_busy;
  logic         r_start_ready;
  logic         w_clear;
  logic         w_enable;
  logic         w_wrap_c;
  logic         w_pause;
  logic [A-1:0] w_count;

`ifdef MOD_COUNTER_SEQ_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = pause & 1'b0;
`endif

  mod_cnt_core #(.N(N), .A(A)) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .enable (w_enable),
    .count  (w_count),
    .wrap_c (w_wrap_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Priority inside a run: abort, then pause, then count step. Leaving HOLD counts on the same edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_wraps_left_nxt = r_wraps_left;
    w_clear          = 1'b0;
    w_enable         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_valid && r_start_ready) begin
          if (start_wraps == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt      = ST_RUN;
            w_clear          = 1'b1;
            w_wraps_left_nxt = start_wraps;
          end
        end
      end
      ST_RUN, ST_HOLD: begin
        if (abort) begin
          w_state_nxt      = ST_IDLE;
          w_clear          = 1'b1;
          w_wraps_left_nxt = '0;
        end else if (w_pause) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_RUN;
          w_enable    = 1'b1;
          if (w_wrap_c) begin
            w_wraps_left_nxt = W'(r_wraps_left - W'(1));
            if (r_wraps_left == W'(1)) w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wraps_left  <= '0;
      r_wrap_pulse  <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b0;
    end else begin
      r_wraps_left  <= w_wraps_left_nxt;
      r_wrap_pulse  <= w_enable & w_wrap_c;
      r_done        <= (w_state_nxt == ST_DONE);
      r_busy        <= is_busy(w_state_nxt);
      r_start_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign start_ready = r_start_ready;
  assign counter     = w_count;
  assign wrap_pulse  = r_wrap_pulse;
  assign wraps_left  = r_wraps_left;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_mod_counter_seq.sv
// Directed bench for mod_counter_seq with a cycle model feeding an expected-output queue.
module tb_mod_counter_seq;

  localparam int unsigned N = 10;
  localparam int unsigned A = 4;
  localparam int unsigned W = 8;
`ifdef MOD_COUNTER_SEQ_PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] start_wraps;
  logic         pause;
  logic         abort;
  logic [A-1:0] counter;
  logic         wrap_pulse;
  logic [W-1:0] wraps_left;
  logic         busy;
  logic         done;

  mod_counter_seq #(.N(N), .A(A), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_wraps (start_wraps),
    .pause       (pause),
    .abort       (abort),
    .counter     (counter),
    .wrap_pulse  (wrap_pulse),
    .wraps_left  (wraps_left),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rdy;
    logic [A-1:0] cnt;
    logic         wp;
    logic [W-1:0] wl;
    logic         bsy;
    logic         dn;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 run, 2 hold, 3 done
  int m_st, m_cnt, m_wl;
  bit m_wp, m_rdy;
  int busy_seen, wp_seen, done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    m_wp = 1'b0;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_wl = 0; m_rdy = 1'b0;
    end else begin
      case (m_st)
        0: if (start_valid && m_rdy) begin
             if (start_wraps == 0) m_st = 3;
             else begin m_st = 1; m_cnt = 0; m_wl = int'(start_wraps); end
           end
        1, 2: begin
          if (abort) begin
            m_st = 0; m_cnt = 0; m_wl = 0;
          end else if (PE && pause) begin
            m_st = 2;
          end else begin
            m_st = 1;
            if (m_cnt == N - 1) begin
              m_cnt = 0; m_wp = 1'b1; m_wl = m_wl - 1;
              if (m_wl == 0) m_st = 3;
            end else begin
              m_cnt = m_cnt + 1;
            end
          end
        end
        default: m_st = 0;
      endcase
      m_rdy = (m_st == 0);
    end
    e.rdy = m_rdy;
    e.cnt = A'(m_cnt);
    e.wp  = m_wp;
    e.wl  = W'(m_wl);
    e.bsy = (m_st == 1) || (m_st == 2);
    e.dn  = (m_st == 3);
    q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("start_ready", 32'(start_ready), 32'(e.rdy));
    chk("counter",     32'(counter),     32'(e.cnt));
    chk("wrap_pulse",  32'(wrap_pulse),  32'(e.wp));
    chk("wraps_left",  32'(wraps_left),  32'(e.wl));
    chk("busy",        32'(busy),        32'(e.bsy));
    chk("done",        32'(done),        32'(e.dn));
    if (busy === 1'b1)       busy_seen++;
    if (wrap_pulse === 1'b1) wp_seen++;
    if (done === 1'b1)       done_seen++;
  endtask

  task automatic clr_stats();
    busy_seen = 0; wp_seen = 0; done_seen = 0;
  endtask

  task automatic run_to_done(input int max, input string tag);
    for (int i = 0; i < max && done_seen == 0; i++) cycle();
    chk(tag, 32'(done_seen), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; start_wraps = '0; pause = 1'b0; abort = 1'b0;
    m_st = 0; m_cnt = 0; m_wl = 0; m_wp = 1'b0; m_rdy = 1'b0;
    clr_stats();

    // reset state
    cycle(); cycle();
    chk("rst_ready", 32'(start_ready), 32'd0);
    chk("rst_counter", 32'(counter), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cycle();
    chk("ready_after_reset", 32'(start_ready), 32'd1);

    // basic run of 3 wraps
    clr_stats();
    start_valid = 1'b1; start_wraps = 8'd3;
    cycle();
    start_valid = 1'b0;
    run_to_done(100, "basic_done_timeout");
    chk("basic_run_cycles", 32'(busy_seen), 32'd30);
    chk("basic_wrap_pulses", 32'(wp_seen), 32'd3);
    cycle();
    chk("basic_ready_after_done", 32'(start_ready), 32'd1);
    chk("basic_done_once", 32'(done_seen), 32'd1);

    // zero wraps
    clr_stats();
    start_valid = 1'b1; start_wraps = 8'd0;
    cycle();
    start_valid = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_counter", 32'(counter), 32'd0);
    cycle();
    chk("zero_ready", 32'(start_ready), 32'd1);
    chk("zero_no_wrap", 32'(wp_seen), 32'd0);

    // abort and pause ignored in IDLE
    abort = 1'b1; pause = 1'b1;
    cycle();
    abort = 1'b0; pause = 1'b0;
    chk("idle_ignore_ready", 32'(start_ready), 32'd1);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // abort on the final-wrap cycle
    clr_stats();
    start_valid = 1'b1; start_wraps = 8'd2;
    cycle();
    start_valid = 1'b0;
    for (int i = 0; i < 40 && !(counter == 4'd9 && wraps_left == 8'd1); i++) cycle();
    chk("abort_reach", 32'(counter == 4'd9 && wraps_left == 8'd1), 32'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_counter", 32'(counter), 32'd0);
    chk("abort_wrap_pulse", 32'(wrap_pulse), 32'd0);
    chk("abort_wraps_left", 32'(wraps_left), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    cycle(); cycle();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_ready", 32'(start_ready), 32'd1);

    // reset mid-run, with a start request during the run
    clr_stats();
    start_valid = 1'b1; start_wraps = 8'd5;
    cycle();
    start_wraps = 8'd0;
    cycle();
    start_valid = 1'b0;
    chk("ignored_start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && counter != 4'd6; i++) cycle();
    chk("rstmid_reach", 32'(counter), 32'd6);
    reset = 1'b1;
    cycle();
    chk("rstmid_counter", 32'(counter), 32'd0);
    chk("rstmid_wraps_left", 32'(wraps_left), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(start_ready), 32'd0);
    reset = 1'b0;
    cycle();
    chk("rstmid_ready_after", 32'(start_ready), 32'd1);
    chk("rstmid_no_done", 32'(done_seen), 32'd0);

    // pause for 5 cycles at counter 4 (ignored unless pause is enabled)
    clr_stats();
    start_valid = 1'b1; start_wraps = 8'd1;
    cycle();
    start_valid = 1'b0;
    for (int i = 0; i < 20 && counter != 4'd4; i++) cycle();
    chk("pause_reach", 32'(counter), 32'd4);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("pause_counter", 32'(counter), PE ? 32'd4 : 32'(5 + k));
      chk("pause_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    cycle();
    chk("pause_resume", 32'(counter), PE ? 32'd5 : 32'd0);
    run_to_done(40, "pause_done_timeout");
    chk("pause_run_cycles", 32'(busy_seen), PE ? 32'd15 : 32'd10);
    cycle();
    chk("pause_ready_after", 32'(start_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
